conv_row_scheduler: RTL

Sequences one time-multiplexed binary MAC PE to compute a 1-D convolution of one binary ifmap row with one binary filter row. It produces OFMAP_W = IFMAP_W - FILTER_W + 1 partial sums of PSUM_W bits, streamed out over a valid/ready handshake. The controller implements zero gating itself: when the ifmap bit is 0, the PE is not fired and the accumulator holds its value, so psums are never discarded. It sits between the global buffer (config/operand load) and the psum writeback path.

---
 rtl/conv_row_scheduler_pkg.sv | 21 ++
 rtl/conv_row_scheduler_mac_pe.sv | 13 +
 rtl/conv_row_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_row_scheduler_pkg.sv
// Shared types and sizing helpers for the 1-D binary convolution row scheduler.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    EMIT
  } state_e;

  localparam int PSUM_W_DEFAULT = 32;

  function automatic int ofmap_w(input int ifmap_w, input int filter_w);
    return ifmap_w - filter_w + 1;
  endfunction

  // Index width that stays at least one bit even for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_row_scheduler_mac_pe.sv
// Binary MAC processing element: adds weight AND ifmap bit to the incoming psum.
module conv_mac_pe #(
  parameter int PSUM_W = 32
) (
  input  logic [PSUM_W-1:0] inpsum,
  input  logic              weight,
  input  logic              infmap_value,
  output logic [PSUM_W-1:0] outpsum
);

  assign outpsum = inpsum + PSUM_W'(weight & infmap_value);

endmodule

// File: rtl/conv_row_scheduler.sv
// Sequences one time-multiplexed binary MAC PE over a filter/ifmap row pair,
// gating the PE off for zero ifmap bits and streaming psums out on valid/ready.
module conv_row_scheduler
  import conv_pkg::*;
#(
  parameter  int FILTER_W = 3,
  parameter  int IFMAP_W  = 8,
  parameter  int PSUM_W   = PSUM_W_DEFAULT,
  localparam int OFMAP_W  = ofmap_w(IFMAP_W, FILTER_W),
  localparam int IDX_W    = idx_w(OFMAP_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [FILTER_W-1:0] cfg_weights,
  input  logic [IFMAP_W-1:0]  cfg_ifmap,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PSUM_W-1:0]   out_psum,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_last,
  output logic                busy,
  output logic [31:0]         zero_skip_count
);

  localparam int TAP_W     = idx_w(FILTER_W);
  localparam int IFM_IDX_W = idx_w(IFMAP_W);

  if (FILTER_W < 1 || FILTER_W > IFMAP_W) begin : g_bad_cfg
    $error("conv_row_scheduler: FILTER_W must be in 1..IFMAP_W");
  end

  state_e               state_q, state_d;
  logic [FILTER_W-1:0]  weights_q, weights_d;
  logic [IFMAP_W-1:0]   ifmap_q, ifmap_d;
  logic [IDX_W-1:0]     pos_q, pos_d;
  logic [TAP_W-1:0]     tap_q, tap_d;
  logic [PSUM_W-1:0]    acc_q, acc_d;
  logic [31:0]          zsc_q, zsc_d;
  logic [PSUM_W-1:0]    psum_q, psum_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic                 last_q, last_d;

  logic [IFM_IDX_W-1:0] ifm_sel;
  logic                 ifm_bit;
  logic                 wt_bit;
  logic [PSUM_W-1:0]    pe_out;
  logic [PSUM_W-1:0]    acc_gated;

  assign ifm_sel = IFM_IDX_W'(pos_q) + IFM_IDX_W'(tap_q);
  assign ifm_bit = ifmap_q[ifm_sel];
  assign wt_bit  = weights_q[tap_q];

  conv_mac_pe #(
    .PSUM_W(PSUM_W)
  ) u_pe (
    .inpsum      (acc_q),
    .weight      (wt_bit),
    .infmap_value(ifm_bit),
    .outpsum     (pe_out)
  );

  // A zero ifmap bit never fires the PE, so the accumulator simply holds.
  assign acc_gated = ifm_bit ? pe_out : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      weights_q <= '0;
      ifmap_q   <= '0;
      pos_q     <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      zsc_q     <= '0;
      psum_q    <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      weights_q <= weights_d;
      ifmap_q   <= ifmap_d;
      pos_q     <= pos_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      zsc_q     <= zsc_d;
      psum_q    <= psum_d;
      index_q   <= index_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    weights_d = weights_q;
    ifmap_d   = ifmap_q;
    pos_d     = pos_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    zsc_d     = zsc_q;
    psum_d    = psum_q;
    index_d   = index_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          weights_d = cfg_weights;
          ifmap_d   = cfg_ifmap;
          pos_d     = '0;
          tap_d     = '0;
          acc_d     = '0;
          zsc_d     = '0;
          state_d   = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_gated;
        if (!ifm_bit && zsc_q != 32'hFFFF_FFFF) begin
          zsc_d = zsc_q + 32'd1;
        end
        if (tap_q == TAP_W'(FILTER_W - 1)) begin
          psum_d  = acc_gated;
          index_d = pos_q;
          last_d  = (pos_q == IDX_W'(OFMAP_W - 1));
          state_d = EMIT;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            pos_d   = pos_q + IDX_W'(1);
            tap_d   = '0;
            acc_d   = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign out_valid       = (state_q == EMIT);
  assign out_psum        = psum_q;
  assign out_index       = index_q;
  assign out_last        = last_q;
  assign zero_skip_count = zsc_q;

endmodule
